// File: rtl/hms_to_seconds.sv
// hms_to_seconds
//   Converts an hours/minutes/seconds triple into total elapsed seconds
//   (hours*3600 + mins*60 + secs) with a sequential shift-add datapath.
//   There are no multipliers. The result feeds alarm compare and elapsed-time
//   logging, which both work in flat seconds.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; captures operands on an accepted start
//   MUL_H | one hours bit per cycle, LSB first: acc += 3600<<i when set
//   MUL_M | one minutes bit per cycle, LSB first: acc += 60<<j when set
//   ADD   | adds secs, publishes total_secs/err, pulses done
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   start       conversion request, sampled only in IDLE
//   hours       hours operand (HOURS_W bits), captured on accepted start
//   mins        minutes operand, legal 0..59
//   secs        seconds operand, legal 0..59
//   busy        conversion in progress
//   done        one-cycle pulse, total_secs/err valid
//   err         last conversion had mins>59 or secs>59
//   total_secs  result, held until the next done
module hms_to_seconds #(
   parameter int HOURS_W = 16,
   parameter int OUT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [HOURS_W-1:0] hours,
   input  logic [7:0]         mins,
   input  logic [7:0]         secs,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [OUT_W-1:0]   total_secs
);

   // The same counter walks the hours bits and then the 8 minutes bits.
   localparam int CNT_W = (HOURS_W > 8) ? $clog2(HOURS_W) : 3;

   typedef enum logic [1:0] {IDLE, MUL_H, MUL_M, ADD} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               cnt_tc;
   logic [HOURS_W-1:0] hours_sh;
   logic [7:0]         mins_sh;
   logic [7:0]         secs_r;
   logic               range_err;
   logic [OUT_W-1:0]   acc;
   logic [OUT_W-1:0]   addend;

   assign cnt_tc = (cnt == '0);
   assign busy   = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)  state_nxt = MUL_H;
         MUL_H:   if (cnt_tc) state_nxt = MUL_M;
         MUL_M:   if (cnt_tc) state_nxt = ADD;
         ADD:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         hours_sh   <= '0;
         mins_sh    <= '0;
         secs_r     <= '0;
         range_err  <= 1'b0;
         acc        <= '0;
         addend     <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         total_secs <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  hours_sh  <= hours;
                  mins_sh   <= mins;
                  secs_r    <= secs;
                  acc       <= '0;
                  addend    <= OUT_W'(3600);
                  cnt       <= CNT_W'(HOURS_W - 1);
                  range_err <= (mins > 8'd59) || (secs > 8'd59);
               end
            end
            MUL_H: begin
               if (hours_sh[0]) acc <= acc + addend;
               hours_sh <= hours_sh >> 1;
               // On the last hours bit, reload the addend for the minutes pass.
               if (cnt_tc) begin
                  addend <= OUT_W'(60);
                  cnt    <= CNT_W'(7);
               end else begin
                  addend <= addend << 1;
                  cnt    <= cnt - CNT_W'(1);
               end
            end
            MUL_M: begin
               if (mins_sh[0]) acc <= acc + addend;
               mins_sh <= mins_sh >> 1;
               addend  <= addend << 1;
               if (!cnt_tc) cnt <= cnt - CNT_W'(1);
            end
            ADD: begin
               total_secs <= range_err ? '0 : (acc + OUT_W'(secs_r));
               err        <= range_err;
               done       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hms_to_seconds.sv
module tb_hms_to_seconds;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] hours;
   logic [7:0]  mins;
   logic [7:0]  secs;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] total_secs;

   int total = 0;
   int bad   = 0;
   int viol  = 0;
   int done_cnt = 0;
   logic prev_done = 1'b0;

   hms_to_seconds #(.HOURS_W(16), .OUT_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .hours(hours), .mins(mins),
      .secs(secs), .busy(busy), .done(done), .err(err),
      .total_secs(total_secs)
   );

   always #5 clk = ~clk;

   // Protocol monitor: busy/done exclusive, done never two cycles in a row.
   always @(negedge clk) begin
      if (!rst) begin
         if (busy && done) viol++;
         if (done && prev_done) viol++;
         if (done) done_cnt++;
      end
      prev_done = done;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called #1 after an edge; that next edge is N. Operands are scrambled
   // afterwards to show they were captured.
   task automatic launch(input logic [15:0] h, input logic [7:0] m, input logic [7:0] s);
      hours = h; mins = m; secs = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      hours = ~h; mins = 8'hA5; secs = 8'h5A;
   endtask

   // Counts edges after N until done is seen; 99 on timeout.
   task automatic wait_done(output int lat);
      lat = 99;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic conv(input string tag, input logic [15:0] h, input logic [7:0] m,
                       input logic [7:0] s, input logic [31:0] exp_t, input logic exp_e);
      int lat;
      launch(h, m, s);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      wait_done(lat);
      check({tag, "_lat"}, lat, 32'd25);
      check({tag, "_total"}, total_secs, exp_t);
      check({tag, "_err"}, {31'd0, err}, {31'd0, exp_e});
   endtask

   initial begin
      int lat;
      int dc;
      logic [15:0] h;
      logic [7:0]  m, s;

      rst = 1'b1; start = 1'b0; hours = '0; mins = '0; secs = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_total", total_secs, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      conv("t1_1_01_01", 16'd1, 8'd1, 8'd1, 32'd3661, 1'b0);
      @(posedge clk); #1;
      check("t1_done_width", {31'd0, done}, 32'd0);
      check("t1_total_hold", total_secs, 32'd3661);

      conv("t2_0_59_59", 16'd0, 8'd59, 8'd59, 32'd3599, 1'b0);
      conv("t2_max", 16'd65535, 8'd59, 8'd59, 32'd235929599, 1'b0);
      conv("t3_min60", 16'd0, 8'd60, 8'd0, 32'd0, 1'b1);
      conv("t3_sec60", 16'd0, 8'd0, 8'd60, 32'd0, 1'b1);
      conv("t3_clear", 16'd0, 8'd0, 8'd0, 32'd0, 1'b0);
      conv("t3_zero_h", 16'd3, 8'd0, 8'd7, 32'd10807, 1'b0);

      // start during busy is ignored; start in the done cycle is accepted
      launch(16'd1, 8'd1, 8'd1);
      repeat (4) @(posedge clk);
      #1;
      hours = 16'd3; mins = 8'd3; secs = 8'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 6; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
         lat = 99;
      end
      check("t4_lat", lat, 32'd25);
      check("t4_first", total_secs, 32'd3661);
      launch(16'd2, 8'd0, 8'd0);
      wait_done(lat);
      check("t4_b2b_lat", lat, 32'd25);
      check("t4_second", total_secs, 32'd7200);

      // reset mid-conversion
      launch(16'd5, 8'd5, 8'd5);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_done", {31'd0, done}, 32'd0);
      check("t5_total", total_secs, 32'd0);
      dc = done_cnt;
      repeat (30) @(posedge clk);
      #1;
      check("t5_no_done", done_cnt, dc);
      conv("t5_2_00_00", 16'd2, 8'd0, 8'd0, 32'd7200, 1'b0);

      // random legal triples against h*3600+m*60+s
      for (int i = 0; i < 1000; i++) begin
         h = 16'($urandom_range(0, 65535));
         m = 8'($urandom_range(0, 59));
         s = 8'($urandom_range(0, 59));
         launch(h, m, s);
         wait_done(lat);
         check("rnd_lat", lat, 32'd25);
         check("rnd_total", total_secs, 32'(h) * 32'd3600 + 32'(m) * 32'd60 + 32'(s));
         check("rnd_err", {31'd0, err}, 32'd0);
      end

      @(posedge clk); #1;
      check("protocol_viol", viol, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
